// File: rtl/gpio_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_port_ctrl
// Description : Byte-bus GPIO controller with per-pin direction, input
//               synchroniser, rise/fall edge interrupts with mask and W1C
//               status. Optional per-pin debounce is built when the macro
//               GPIO_DEBOUNCE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_port_ctrl #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [7:0]       data_i,
  output logic [7:0]       data_o,
  output logic             ready,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] oe,
  output logic             interrupt
);

  localparam int NB = WIDTH / 8;
  localparam int FW = $clog2(SYNC_STAGES + 1);

  localparam logic [3:0] REG_OUT   = 4'd0;
  localparam logic [3:0] REG_DIR   = 4'd1;
  localparam logic [3:0] REG_IN    = 4'd2;
  localparam logic [3:0] REG_IEN   = 4'd3;
  localparam logic [3:0] REG_STAT  = 4'd4;
  localparam logic [3:0] REG_RISE  = 4'd5;
  localparam logic [3:0] REG_FALL  = 4'd6;

  // Registers
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] irq_en_q;
  logic [WIDTH-1:0] irq_stat_q;
  logic [WIDTH-1:0] edge_rise_q;
  logic [WIDTH-1:0] edge_fall_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] in_val;
  logic [FW-1:0]    fill_cnt;
  logic             armed;

  // Bus decode
  logic [3:0]       reg_idx;
  logic [1:0]       lane;
  logic             lane_ok;
  logic             access;
  logic             do_wr;
  logic             do_rd;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_word;
  logic [7:0]       rd_byte;
  logic [WIDTH-1:0] stat_clr;
  logic [WIDTH-1:0] edge_set;

  // Upper address bits are don't-care; the register file aliases every 64 bytes
  logic unused_addr;
  assign unused_addr = &{1'b0, addr[31:6]};

  assign reg_idx = addr[5:2];
  assign lane    = addr[1:0];
  assign lane_ok = (32'(lane) < NB);
  assign access  = cs & (rd ^ wr);
  assign do_wr   = access & wr & lane_ok;
  assign do_rd   = access & rd;
  assign wdata   = {NB{data_i}};

  // Byte-lane write mask selected by addr[1:0]
  always_comb begin
    wmask = '0;
    for (int b = 0; b < NB; b++) begin
      if (lane == 2'(b)) wmask[b*8 +: 8] = 8'hFF;
    end
  end

  // Read data selection; unmapped indices and lanes read as zero
  always_comb begin
    rd_word = '0;
    rd_byte = 8'h00;
    case (reg_idx)
      REG_OUT:  rd_word = out_q;
      REG_DIR:  rd_word = dir_q;
      REG_IN:   rd_word = in_val;
      REG_IEN:  rd_word = irq_en_q;
      REG_STAT: rd_word = irq_stat_q;
      REG_RISE: rd_word = edge_rise_q;
      REG_FALL: rd_word = edge_fall_q;
      default:  rd_word = '0;
    endcase
    for (int b = 0; b < NB; b++) begin
      if (lane == 2'(b)) rd_byte = rd_word[b*8 +: 8];
    end
  end

  // Edge events are suppressed until prev holds a real synchronised sample
  assign edge_set = {WIDTH{armed}} &
                    (( in_val & ~prev_q & edge_rise_q) |
                     (~in_val &  prev_q & edge_fall_q));
  assign stat_clr = (do_wr && reg_idx == REG_STAT) ? (wdata & wmask) : '0;

  // Pad input synchroniser chain
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= inp;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES + 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    logic [DBW-1:0] cnt;
    logic           db;
    // Flip the pin only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt <= '0;
        db  <= 1'b0;
      end else if (sync_q[SYNC_STAGES-1][i] != db) begin
        if (cnt == DBW'(DB_CYCLES - 1)) begin
          cnt <= '0;
          db  <= sync_q[SYNC_STAGES-1][i];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
    assign in_val[i] = db;
  end
`else
  localparam int unused_db_cycles = DB_CYCLES;
  assign in_val = sync_q[SYNC_STAGES-1];
`endif

  // Post-reset fill tracking and previous-sample register for edge detect
  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_cnt <= '0;
      armed    <= 1'b0;
      prev_q   <= '0;
    end else begin
      if (fill_cnt != FW'(SYNC_STAGES)) fill_cnt <= fill_cnt + 1'b1;
      armed  <= armed | (fill_cnt == FW'(SYNC_STAGES));
      prev_q <= in_val;
    end
  end

  // Control/status register writes; a new edge beats a same-cycle W1C clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q       <= '0;
      dir_q       <= '0;
      irq_en_q    <= '0;
      irq_stat_q  <= '0;
      edge_rise_q <= '0;
      edge_fall_q <= '0;
    end else begin
      if (do_wr && reg_idx == REG_OUT)  out_q       <= (out_q       & ~wmask) | (wdata & wmask);
      if (do_wr && reg_idx == REG_DIR)  dir_q       <= (dir_q       & ~wmask) | (wdata & wmask);
      if (do_wr && reg_idx == REG_IEN)  irq_en_q    <= (irq_en_q    & ~wmask) | (wdata & wmask);
      if (do_wr && reg_idx == REG_RISE) edge_rise_q <= (edge_rise_q & ~wmask) | (wdata & wmask);
      if (do_wr && reg_idx == REG_FALL) edge_fall_q <= (edge_fall_q & ~wmask) | (wdata & wmask);
      irq_stat_q <= (irq_stat_q & ~stat_clr) | edge_set;
    end
  end

  // Bus response and registered interrupt
  always_ff @(posedge clk) begin
    if (!rst) begin
      ready     <= 1'b0;
      data_o    <= 8'h00;
      interrupt <= 1'b0;
    end else begin
      ready     <= access;
      if (do_rd) data_o <= rd_byte;
      interrupt <= |(irq_stat_q & irq_en_q);
    end
  end

  assign out = out_q & dir_q;
  assign oe  = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_port_ctrl
// Description : Directed self-checking bench for gpio_port_ctrl; read
//               expectations go through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_port_ctrl;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cs = 1'b0;
  logic             rd = 1'b0;
  logic             wr = 1'b0;
  logic [31:0]      addr = '0;
  logic [7:0]       data_i = '0;
  logic [WIDTH-1:0] inp = '0;
  logic [7:0]       data_o;
  logic             ready;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] oe;
  logic             interrupt;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  gpio_port_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DB_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .data_i(data_i), .data_o(data_o), .ready(ready), .inp(inp),
    .out(out), .oe(oe), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic is_wr, input logic [31:0] a, input logic [7:0] d,
                     input logic [7:0] exp, input string tag);
    if (!is_wr) exp_q.push_back(exp);
    @(negedge clk);
    cs = 1'b1; rd = ~is_wr; wr = is_wr; addr = a; data_i = d;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    chk({tag, " ready"}, 64'(ready), 64'd1);
    if (!is_wr) chk(tag, 64'(data_o), 64'(exp_q.pop_front()));
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [7:0] d);
    bus(1'b1, a, d, 8'h00, "wr");
  endtask

  task automatic rd_reg(input logic [31:0] a, input logic [7:0] exp, input string tag);
    bus(1'b0, a, 8'h00, exp, tag);
    @(negedge clk);
    chk({tag, " ready_drop"}, 64'(ready), 64'd0);
  endtask

  initial begin
    int cyc;

    // Reset, with a write attempted while reset is asserted
    inp = 32'hF0F0F0F0;
    repeat (2) @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = 32'h04; data_i = 8'hFF;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    chk("rst ready", 64'(ready), 64'd0);
    chk("rst data_o", 64'(data_o), 64'h00);
    chk("rst interrupt", 64'(interrupt), 64'd0);
    chk("rst out", 64'(out), 64'h0);
    chk("rst oe", 64'(oe), 64'h0);
    rst = 1'b1;
    repeat (5 + DB) @(negedge clk);

    // IN reads of pad state
    rd_reg(32'h08, 8'hF0, "in b0");
    rd_reg(32'h09, 8'hF0, "in b1");
    rd_reg(32'h0A, 8'hF0, "in b2");
    rd_reg(32'h0B, 8'hF0, "in b3");
    chk("irq idle", 64'(interrupt), 64'd0);
    rd_reg(32'h10, 8'h00, "stat idle");

    // Direction and output
    wr_reg(32'h04, 8'hFF); wr_reg(32'h05, 8'hFF);
    wr_reg(32'h06, 8'hFF); wr_reg(32'h07, 8'hFF);
    wr_reg(32'h00, 8'hA5);
    chk("out a5", 64'(out), 64'h000000A5);
    chk("oe all", 64'(oe), 64'hFFFFFFFF);
    @(negedge clk);
    cs = 1'b0; wr = 1'b1; addr = 32'h00; data_i = 8'h5A;
    @(negedge clk);
    wr = 1'b0;
    chk("cs0 ready", 64'(ready), 64'd0);
    chk("cs0 out", 64'(out), 64'h000000A5);
    // OUT stored while DIR=0, visible once DIR=1
    wr_reg(32'h04, 8'h00);
    chk("dir0 out", 64'(out), 64'h0);
    wr_reg(32'h00, 8'h3C);
    chk("stored out", 64'(out), 64'h0);
    wr_reg(32'h04, 8'hFF);
    chk("restored out", 64'(out), 64'h0000003C);
    rd_reg(32'h00, 8'h3C, "rd out");

    // Rising edge on pin 0
    wr_reg(32'h14, 8'h01);
    wr_reg(32'h0C, 8'h01);
    @(negedge clk);
    inp[0] = 1'b1;
    cyc = 0;
    for (int i = 0; i < SYNC + DB + 6; i++) begin
      @(negedge clk);
      cyc++;
      if (interrupt) break;
    end
    chk("rise irq", 64'(interrupt), 64'd1);
    chk("rise latency ok", 64'(cyc <= SYNC + 2 + DB), 64'd1);
    rd_reg(32'h10, 8'h01, "rise stat");
    wr_reg(32'h10, 8'h01);
    chk("clr irq held", 64'(interrupt), 64'd1);
    @(negedge clk);
    chk("clr irq drop", 64'(interrupt), 64'd0);

    // Falling edge on pin 8 with interrupt masked
    wr_reg(32'h0C, 8'h00);
    wr_reg(32'h19, 8'h01);
    inp[8] = 1'b1;
    repeat (4 + DB + 2) @(negedge clk);
    inp[8] = 1'b0;
    repeat (5 + DB) @(negedge clk);
    rd_reg(32'h11, 8'h01, "fall stat");
    chk("fall masked", 64'(interrupt), 64'd0);
    wr_reg(32'h0D, 8'h01);
    chk("en irq reg", 64'(interrupt), 64'd0);
    @(negedge clk);
    chk("en irq", 64'(interrupt), 64'd1);
    wr_reg(32'h11, 8'h00);
    rd_reg(32'h11, 8'h01, "w1c zero keeps");
    wr_reg(32'h11, 8'h01);
    rd_reg(32'h11, 8'h00, "w1c one clears");

    // Unmapped, aliased and illegal accesses
    rd_reg(32'h1C, 8'h00, "idx7");
    wr_reg(32'h1C, 8'hFF);
    rd_reg(32'h1C, 8'h00, "idx7 after wr");
    rd_reg(32'h3C, 8'h00, "idx15");
    rd_reg(32'hFFFFFF48, 8'hF1, "alias in");
    wr_reg(32'h00000040, 8'h55);
    chk("alias out", 64'(out), 64'h00000055);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 32'h00; data_i = 8'h11;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    chk("rdwr ready", 64'(ready), 64'd0);
    chk("rdwr out", 64'(out), 64'h00000055);

    // Pin 1 filtering / tracking
    wr_reg(32'h14, 8'h03);
`ifdef GPIO_DEBOUNCE_EN
    inp[1] = 1'b1;
    repeat (5) @(negedge clk);
    inp[1] = 1'b0;
    repeat (25) @(negedge clk);
    rd_reg(32'h08, 8'hF1, "glitch in");
    rd_reg(32'h10, 8'h00, "glitch stat");
    inp[1] = 1'b1;
    repeat (12) @(negedge clk);
    rd_reg(32'h08, 8'hF1, "db early");
    repeat (8) @(negedge clk);
    rd_reg(32'h08, 8'hF3, "db settled");
    rd_reg(32'h10, 8'h02, "db stat");
`else
    inp[1] = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    rd_reg(32'h08, 8'hF3, "sync in");
    rd_reg(32'h10, 8'h02, "sync stat");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
